uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_frame_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_frame.sv | 135 +++++++++++++
 tb/tb_uart_tx_frame.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and baud divisor.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  function automatic int unsigned clks_per_baud(input int unsigned clk_hz,
                                                input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side handshake and line outputs of the UART transmitter.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 i_TX_VALID;
  logic [DATA_BITS-1:0] i_DATA_IN;
  logic                 o_TX_READY;
  logic                 o_TX_BUSY;
  logic                 o_TX_DONE;
  logic                 o_TX;

  modport master (
    output i_TX_VALID, i_DATA_IN,
    input  o_TX_READY, o_TX_BUSY, o_TX_DONE, o_TX
  );

  modport slave (
    input  i_TX_VALID, i_DATA_IN,
    output o_TX_READY, o_TX_BUSY, o_TX_DONE, o_TX
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter 0..CLKS_PER_BAUD-1 with sync reload and a wrap tick.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BAUD = 2
) (
  input  logic i_CLK,
  input  logic i_RESET,
  input  logic i_CLEAR,
  input  logic i_EN,
  output logic o_TICK
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BAUD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_CLEAR) begin
      cnt_d = '0;
    end else if (i_EN) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_TICK = i_EN && !i_CLEAR && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// STOP_BITS stop bits, one character per valid/ready handshake.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  uart_tx_frame_if.slave   bus
);
  localparam int unsigned CLKS_PER_BAUD = clks_per_baud(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  if (CLKS_PER_BAUD < 2) begin : g_bad_baud
    $error("CLKS_PER_BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > PARITY_ODD) begin : g_bad_parity
    $error("PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 accept;
  logic                 tick;

  assign accept = bus.i_TX_VALID && ready_q;

  uart_baud_gen #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_baud (
    .i_CLK   (i_CLK),
    .i_RESET (i_RESET),
    .i_CLEAR (accept),
    .i_EN    (busy_q),
    .o_TICK  (tick)
  );

  // Bit counter indexes data bits in DATA and stop bits in STOP.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q   <= bus.i_DATA_IN;
            parity_q  <= (^bus.i_DATA_IN) ^ (PARITY_MODE == PARITY_ODD);
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              if (PARITY_MODE != PARITY_NONE) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_TX       = tx_q;
  assign bus.o_TX_READY = ready_q;
  assign bus.o_TX_BUSY  = busy_q;
  assign bus.o_TX_DONE  = done_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: 8N1, 7E2 and 9O1 instances at 10 clocks per bit.
module tb_uart_tx_frame;
  localparam int C = 10;
  localparam int DB [3] = '{8, 7, 9};
  localparam int PM [3] = '{0, 1, 2};
  localparam int SB [3] = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  logic [3:0] obs;   // {tx, busy, ready, done}
  bit   exp_bits[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(9)) if2 ();

  uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY_MODE(0), .STOP_BITS(1))
    dut0 (.i_CLK(clk), .i_RESET(rst), .bus(if0));
  uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY_MODE(1), .STOP_BITS(2))
    dut1 (.i_CLK(clk), .i_RESET(rst), .bus(if1));
  uart_tx_frame #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(9),
                  .PARITY_MODE(2), .STOP_BITS(1))
    dut2 (.i_CLK(clk), .i_RESET(rst), .bus(if2));

  always_comb begin
    case (sel)
      0:       obs = {if0.o_TX, if0.o_TX_BUSY, if0.o_TX_READY, if0.o_TX_DONE};
      1:       obs = {if1.o_TX, if1.o_TX_BUSY, if1.o_TX_READY, if1.o_TX_DONE};
      default: obs = {if2.o_TX, if2.o_TX_BUSY, if2.o_TX_READY, if2.o_TX_DONE};
    endcase
  end

  task automatic drive(input int cfg, input logic v, input logic [8:0] d);
    case (cfg)
      0: begin if0.i_TX_VALID = v; if0.i_DATA_IN = d[7:0]; end
      1: begin if1.i_TX_VALID = v; if1.i_DATA_IN = d[6:0]; end
      default: begin if2.i_TX_VALID = v; if2.i_DATA_IN = d; end
    endcase
  endtask

  // Line image of one character: start, data LSB first, parity, stop bits.
  function automatic void build_frame(input int cfg, input logic [8:0] d);
    bit p = 1'b0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DB[cfg]; i++) begin
      exp_bits.push_back(d[i]);
      p ^= d[i];
    end
    if (PM[cfg] == 1) exp_bits.push_back(p);
    if (PM[cfg] == 2) exp_bits.push_back(!p);
    for (int s = 0; s < SB[cfg]; s++) exp_bits.push_back(1'b1);
  endfunction

  function automatic logic [8:0] rand_char(input int cfg);
    logic [8:0] mask = 9'((1 << DB[cfg]) - 1);
    return 9'($urandom) & mask;
  endfunction

  // Entered and left at #1 after a rising edge; left right after the done edge.
  task automatic run_frame(input int cfg, input logic [8:0] d, input bit hold,
                           input logic [8:0] nd, input string name, output int e0);
    int waited = 0;
    int n;
    logic [3:0] exp;
    e0 = -1;
    sel = cfg;
    build_frame(cfg, d);
    n = exp_bits.size();
    #0;
    while (!obs[1] && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!obs[1]) begin
      checks++; errors++;
      $display("FAIL %s ready_timeout: ready=%b required 1", name, obs[1]);
      return;
    end
    drive(cfg, 1'b1, d);
    @(posedge clk);
    #1;
    e0 = cyc;
    if (hold) drive(cfg, 1'b1, nd);
    else drive(cfg, 1'b0, d);
    for (int k = 0; k <= n * C; k++) begin
      exp = (k < n * C) ? {exp_bits[k / C], 3'b100} : 4'b1011;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s k=%0d: tx/busy/ready/done=%b required %b", name, k, obs, exp);
      end
      if (k < n * C) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) drive(c, 1'b1, 9'h1FF);
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      sel = c;
      #1;
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL reset_state cfg%0d: got %b required 1010", c, obs);
      end
    end
    for (int c = 0; c < 3; c++) drive(c, 1'b0, 9'h000);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_vs_accept();
    sel = 0;
    rst = 1'b1;
    drive(0, 1'b1, 9'h0FF);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 9'h000);
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL reset_wins k=%0d: got %b required 1010", k, obs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_idle();
    sel = 0;
    for (int k = 0; k < 1000; k++) begin
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL idle k=%0d: got %b required 1010", k, obs);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_8n1();
    int e0;
    run_frame(0, 9'h0A5, 1'b0, 9'h0, "8n1_a5", e0);
    repeat (3) run_frame(0, rand_char(0), 1'b0, 9'h0, "8n1_rand", e0);
  endtask

  task automatic test_7e2();
    int e0;
    run_frame(1, 9'h003, 1'b0, 9'h0, "7e2_03", e0);
    run_frame(1, 9'h007, 1'b0, 9'h0, "7e2_07", e0);
    repeat (3) run_frame(1, rand_char(1), 1'b0, 9'h0, "7e2_rand", e0);
  endtask

  task automatic test_9o1();
    int e0;
    run_frame(2, 9'h1FF, 1'b0, 9'h0, "9o1_1ff", e0);
    run_frame(2, 9'h000, 1'b0, 9'h0, "9o1_000", e0);
    repeat (3) run_frame(2, rand_char(2), 1'b0, 9'h0, "9o1_rand", e0);
  endtask

  task automatic test_back_to_back();
    int e0a, e0b;
    run_frame(0, 9'h055, 1'b1, 9'h0AA, "b2b_55", e0a);
    run_frame(0, 9'h0AA, 1'b0, 9'h0, "b2b_aa", e0b);
    checks++;
    if (e0b - e0a !== 101) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d clocks required 101", e0b - e0a);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    sel = 0;
    drive(0, 1'b1, 9'h000);
    @(posedge clk); #1;
    drive(0, 1'b0, 9'h000);
    checks++;
    if (obs !== 4'b0100) begin
      errors++;
      $display("FAIL abort_started: got %b required 0100", obs);
    end
    repeat (34) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (obs !== 4'b1010) begin
      errors++;
      $display("FAIL abort_reset: got %b required 1010", obs);
    end
    for (int k = 0; k < 90; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== 4'b1010) begin
        errors++;
        $display("FAIL abort_no_done k=%0d: got %b required 1010", k, obs);
      end
    end
    run_frame(0, 9'h081, 1'b0, 9'h0, "after_abort_81", e0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 3; c++) drive(c, 1'b0, 9'h000);
    test_reset();
    test_idle();
    test_reset_vs_accept();
    test_8n1();
    test_7e2();
    test_9o1();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
